// File: rtl/mac_pkg.sv
// Shared constants for the dual-dataflow MAC tile: instruction bit positions,
// mode encodings, weight-load state and accumulator clamp limits.
package mac_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_FLUSH = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // LD_READY means the tile will capture the next kernel-load command.
  typedef enum logic {
    LD_READY = 1'b0,
    LD_HELD  = 1'b1
  } ld_state_t;

  function automatic longint psum_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint psum_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational multiply-accumulate: out = c + zext(a) * b, with optional
// clamping to the signed psum_bw range instead of modular wrap.
module mac_sat
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SAT     = 1
) (
  input  logic signed [psum_bw-1:0] c,
  input  logic        [bw-1:0]      a,
  input  logic signed [bw-1:0]      b,
  output logic signed [psum_bw-1:0] out
);

  localparam logic signed [psum_bw-1:0] P_MAX = psum_bw'(psum_max(psum_bw));
  localparam logic signed [psum_bw-1:0] P_MIN = psum_bw'(psum_min(psum_bw));

  logic signed [2*bw:0]    w_a_ext;
  logic signed [2*bw:0]    w_b_ext;
  logic signed [2*bw:0]    w_prod;
  logic signed [psum_bw:0] w_prod_ext;
  logic signed [psum_bw:0] w_c_ext;
  logic signed [psum_bw:0] w_sum;
  logic                    w_ovf;

  // Operands are widened to the product width first so the exact product fits.
  assign w_a_ext    = {{bw{1'b0}}, a};
  assign w_b_ext    = {{(bw + 1){b[bw-1]}}, b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(psum_bw - 2*bw){w_prod[2*bw]}}, w_prod};
  assign w_c_ext    = {c[psum_bw-1], c};
  assign w_sum      = w_c_ext + w_prod_ext;
  assign w_ovf      = w_sum[psum_bw] ^ w_sum[psum_bw-1];

  always_comb begin
    out = w_sum[psum_bw-1:0];
    if ((SAT != 0) && w_ovf) begin
      out = w_sum[psum_bw] ? P_MIN : P_MAX;
    end
  end

endmodule

// File: rtl/mac_tile_dual.sv
// Systolic PE supporting weight-stationary and output-stationary dataflow.
// Activations and instructions move east; psums, weights and drained results move south.
module mac_tile_dual
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  input  logic               valid_n,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s,
  output logic               o_dbg_load_ready,
  output logic               o_dbg_mode_q,
  output logic [bw-1:0]      o_dbg_b_q,
  output logic [psum_bw-1:0] o_dbg_acc
);

  ld_state_t          r_ld_state;
  ld_state_t          w_ld_next;
  logic               w_load_fire;
  logic               r_mode_q;
  logic [bw-1:0]      r_out_e;
  logic [2:0]         r_inst_e;
  logic [psum_bw-1:0] r_out_s;
  logic               r_valid_s;
  logic [psum_bw-1:0] r_acc;
  logic [bw-1:0]      r_b_q;

  logic               w_is_os;
  logic               w_idle;
  logic [psum_bw-1:0] w_mac_c;
  logic [bw-1:0]      w_mac_b;
  logic [psum_bw-1:0] w_mac_out;
  logic [psum_bw-1:0] w_weight_sext;

  assign w_is_os       = (r_mode_q == MODE_OS);
  assign w_idle        = (inst_w == 3'b000);
  assign w_weight_sext = {{(psum_bw - bw){in_n[bw-1]}}, in_n[bw-1:0]};

  // One MAC serves both dataflows: OS accumulates locally with the weight
  // arriving from the north, WS adds the north psum using the held weight.
  assign w_mac_c = w_is_os ? r_acc : in_n;
  assign w_mac_b = w_is_os ? in_n[bw-1:0] : r_b_q;

  mac_sat #(
    .bw      (bw),
    .psum_bw (psum_bw),
    .SAT     (SAT)
  ) u_mac (
    .c   (w_mac_c),
    .a   (in_w),
    .b   (w_mac_b),
    .out (w_mac_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_state <= LD_READY;
    end else begin
      r_ld_state <= w_ld_next;
    end
  end

  // A flush in the same cycle as a load leaves the tile ready again.
  always_comb begin
    w_ld_next   = r_ld_state;
    w_load_fire = 1'b0;
    if (!w_is_os) begin
      if ((r_ld_state == LD_READY) && inst_w[INST_LOAD]) begin
        w_ld_next   = LD_HELD;
        w_load_fire = 1'b1;
      end
      if (inst_w[INST_FLUSH]) begin
        w_ld_next = LD_READY;
      end
    end
  end

  // valid_s has no ready partner: the drain chain cannot stall, so a result
  // is presented for exactly one cycle and the next tile must take it then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode_q  <= MODE_WS;
      r_out_e   <= '0;
      r_inst_e  <= '0;
      r_out_s   <= '0;
      r_valid_s <= 1'b0;
      r_acc     <= '0;
      r_b_q     <= '0;
    end else begin
      if (w_idle) begin
        r_mode_q <= mode;
      end
      if (!w_idle) begin
        r_out_e <= in_w;
      end
      r_inst_e[INST_EXEC]  <= inst_w[INST_EXEC];
      r_inst_e[INST_FLUSH] <= inst_w[INST_FLUSH];
      r_inst_e[INST_LOAD]  <= w_load_fire ? 1'b0 : inst_w[INST_LOAD];
      if (w_load_fire) begin
        r_b_q <= in_w;
      end
      if (!w_is_os) begin
        r_valid_s <= 1'b0;
        if (inst_w[INST_EXEC]) begin
          r_out_s <= w_mac_out;
        end
      end else if (inst_w[INST_FLUSH]) begin
        r_out_s   <= r_acc;
        r_valid_s <= 1'b1;
        r_acc     <= '0;
      end else if (inst_w[INST_EXEC]) begin
        r_acc     <= w_mac_out;
        r_out_s   <= w_weight_sext;
        r_valid_s <= 1'b0;
      end else if (valid_n) begin
        r_out_s   <= in_n;
        r_valid_s <= 1'b1;
      end else begin
        r_valid_s <= 1'b0;
      end
    end
  end

  assign out_e            = r_out_e;
  assign inst_e           = r_inst_e;
  assign out_s            = r_out_s;
  assign valid_s          = r_valid_s && w_is_os;
  assign o_dbg_load_ready = (r_ld_state == LD_READY);
  assign o_dbg_mode_q     = r_mode_q;
  assign o_dbg_b_q        = r_b_q;
  assign o_dbg_acc        = r_acc;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Directed bench for mac_tile_dual: a saturating and a wrapping tile share stimulus.
module tb_mac_tile_dual;

  logic               clk;
  logic               reset;
  logic               mode;
  logic [3:0]         in_w;
  logic [2:0]         inst_w;
  logic [15:0]        in_n;
  logic               valid_n;

  logic [3:0]         out_e;
  logic [2:0]         inst_e;
  logic signed [15:0] out_s;
  logic               valid_s;
  logic               dbg_ld;
  logic               dbg_mode;
  logic [3:0]         dbg_b;
  logic signed [15:0] dbg_acc;

  logic [3:0]         w_out_e;
  logic [2:0]         w_inst_e;
  logic signed [15:0] w_out_s;
  logic               w_valid_s;
  logic               w_dbg_ld;
  logic               w_dbg_mode;
  logic [3:0]         w_dbg_b;
  logic [15:0]        w_dbg_acc;

  int n_checks;
  int n_errors;

  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e),
    .inst_w(inst_w), .inst_e(inst_e), .in_n(in_n), .valid_n(valid_n),
    .out_s(out_s), .valid_s(valid_s), .o_dbg_load_ready(dbg_ld),
    .o_dbg_mode_q(dbg_mode), .o_dbg_b_q(dbg_b), .o_dbg_acc(dbg_acc)
  );

  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(w_out_e),
    .inst_w(inst_w), .inst_e(w_inst_e), .in_n(in_n), .valid_n(valid_n),
    .out_s(w_out_s), .valid_s(w_valid_s), .o_dbg_load_ready(w_dbg_ld),
    .o_dbg_mode_q(w_dbg_mode), .o_dbg_b_q(w_dbg_b), .o_dbg_acc(w_dbg_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] inst, input logic [3:0] a,
                       input logic [15:0] n, input logic vn);
    inst_w  = inst;
    in_w    = a;
    in_n    = n;
    valid_n = vn;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mode  = 1'b0;
    drive(3'b000, 4'h0, 16'h0, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd0 || valid_s !== 1'b0 || out_e !== 4'h0 || inst_e !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_outputs: got out_s=%0d valid_s=%0b out_e=%0h inst_e=%b want 0", out_s, valid_s, out_e, inst_e);
    end
    n_checks++;
    if (dbg_ld !== 1'b1 || dbg_mode !== 1'b0 || dbg_acc !== 16'sd0 || dbg_b !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_state: got ld=%0b mode=%0b acc=%0d b=%0h want 1 0 0 0", dbg_ld, dbg_mode, dbg_acc, dbg_b);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ws_load();
    drive(3'b001, 4'hD, 16'h0, 1'b0);
    tick();
    n_checks++;
    if (inst_e[0] !== 1'b0 || dbg_b !== 4'hD || dbg_ld !== 1'b0) begin
      n_errors++;
      $display("FAIL ws_load_consume: got inst_e0=%0b b_q=%0h ld=%0b want 0 d 0", inst_e[0], dbg_b, dbg_ld);
    end
    n_checks++;
    if (out_e !== 4'hD) begin
      n_errors++;
      $display("FAIL ws_load_out_e: got %0h want d", out_e);
    end
    drive(3'b001, 4'h6, 16'h0, 1'b0);
    tick();
    n_checks++;
    if (inst_e[0] !== 1'b1 || dbg_b !== 4'hD) begin
      n_errors++;
      $display("FAIL ws_load_forward: got inst_e0=%0b b_q=%0h want 1 d", inst_e[0], dbg_b);
    end
  endtask

  task automatic test_ws_mac();
    drive(3'b010, 4'd5, 16'd100, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd85 || inst_e !== 3'b010 || out_e !== 4'd5 || valid_s !== 1'b0) begin
      n_errors++;
      $display("FAIL ws_mac: got out_s=%0d inst_e=%b out_e=%0d valid_s=%0b want 85 010 5 0", out_s, inst_e, out_e, valid_s);
    end
    drive(3'b000, 4'd9, 16'd7, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd85 || out_e !== 4'd5 || inst_e !== 3'b000) begin
      n_errors++;
      $display("FAIL ws_hold: got out_s=%0d out_e=%0d inst_e=%b want 85 5 000", out_s, out_e, inst_e);
    end
  endtask

  task automatic test_saturation();
    drive(3'b100, 4'd0, 16'd0, 1'b0);
    tick();
    n_checks++;
    if (dbg_ld !== 1'b1 || dbg_b !== 4'hD) begin
      n_errors++;
      $display("FAIL ws_release: got ld=%0b b_q=%0h want 1 d", dbg_ld, dbg_b);
    end
    drive(3'b001, 4'd7, 16'd0, 1'b0);
    tick();
    drive(3'b010, 4'd15, 16'd32760, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd32767) begin
      n_errors++;
      $display("FAIL sat_pos: got %0d want 32767", out_s);
    end
    n_checks++;
    if (w_out_s !== -16'sd32671) begin
      n_errors++;
      $display("FAIL wrap_pos: got %0d want -32671", w_out_s);
    end
    drive(3'b100, 4'd0, 16'd0, 1'b0);
    tick();
    drive(3'b001, 4'h8, 16'd0, 1'b0);
    tick();
    drive(3'b010, 4'd15, 16'(-16'sd32700), 1'b0);
    tick();
    n_checks++;
    if (out_s !== -16'sd32768) begin
      n_errors++;
      $display("FAIL sat_neg: got %0d want -32768", out_s);
    end
    n_checks++;
    if (w_out_s !== 16'sd32716) begin
      n_errors++;
      $display("FAIL wrap_neg: got %0d want 32716", w_out_s);
    end
  endtask

  task automatic test_os_acc();
    mode = 1'b1;
    drive(3'b000, 4'd0, 16'd0, 1'b0);
    tick();
    n_checks++;
    if (dbg_mode !== 1'b1) begin
      n_errors++;
      $display("FAIL os_mode_set: got %0b want 1", dbg_mode);
    end
    drive(3'b010, 4'd2, 16'd3, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd3 || valid_s !== 1'b0) begin
      n_errors++;
      $display("FAIL os_fwd_3: got out_s=%0d valid_s=%0b want 3 0", out_s, valid_s);
    end
    drive(3'b010, 4'd15, 16'h0008, 1'b0);
    tick();
    n_checks++;
    if (out_s !== -16'sd8) begin
      n_errors++;
      $display("FAIL os_fwd_m8: got %0d want -8", out_s);
    end
    drive(3'b010, 4'd7, 16'd7, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd7 || dbg_acc !== -16'sd65) begin
      n_errors++;
      $display("FAIL os_fwd_7: got out_s=%0d acc=%0d want 7 -65", out_s, dbg_acc);
    end
    drive(3'b100, 4'd0, 16'd0, 1'b0);
    tick();
    n_checks++;
    if (out_s !== -16'sd65 || valid_s !== 1'b1 || dbg_acc !== 16'sd0) begin
      n_errors++;
      $display("FAIL os_flush: got out_s=%0d valid_s=%0b acc=%0d want -65 1 0", out_s, valid_s, dbg_acc);
    end
    n_checks++;
    if (w_out_s !== -16'sd65) begin
      n_errors++;
      $display("FAIL os_flush_wrap: got %0d want -65", w_out_s);
    end
    tick();
    n_checks++;
    if (out_s !== 16'sd0 || valid_s !== 1'b1) begin
      n_errors++;
      $display("FAIL os_flush_empty: got out_s=%0d valid_s=%0b want 0 1", out_s, valid_s);
    end
  endtask

  task automatic test_priority();
    drive(3'b010, 4'd3, 16'd2, 1'b0);
    tick();
    drive(3'b100, 4'd1, 16'd1234, 1'b1);
    tick();
    n_checks++;
    if (out_s !== 16'sd6 || valid_s !== 1'b1 || dbg_acc !== 16'sd0) begin
      n_errors++;
      $display("FAIL flush_priority: got out_s=%0d valid_s=%0b acc=%0d want 6 1 0", out_s, valid_s, dbg_acc);
    end
    drive(3'b000, 4'd0, 16'd1234, 1'b1);
    tick();
    n_checks++;
    if (out_s !== 16'sd1234 || valid_s !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_pass: got out_s=%0d valid_s=%0b want 1234 1", out_s, valid_s);
    end
    drive(3'b000, 4'd0, 16'd99, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd1234 || valid_s !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_idle: got out_s=%0d valid_s=%0b want 1234 0", out_s, valid_s);
    end
    drive(3'b001, 4'd5, 16'd0, 1'b0);
    tick();
    n_checks++;
    if (inst_e !== 3'b001 || dbg_b !== 4'h8) begin
      n_errors++;
      $display("FAIL os_load_ignored: got inst_e=%b b_q=%0h want 001 8", inst_e, dbg_b);
    end
  endtask

  task automatic test_mode_gating();
    mode = 1'b0;
    drive(3'b010, 4'd1, 16'd0, 1'b0);
    tick();
    n_checks++;
    if (dbg_mode !== 1'b1) begin
      n_errors++;
      $display("FAIL mode_gated: got %0b want 1", dbg_mode);
    end
    drive(3'b000, 4'd0, 16'd0, 1'b1);
    tick();
    n_checks++;
    if (dbg_mode !== 1'b0 || valid_s !== 1'b0) begin
      n_errors++;
      $display("FAIL mode_idle_ws: got mode=%0b valid_s=%0b want 0 0", dbg_mode, valid_s);
    end
  endtask

  task automatic test_async_reset();
    drive(3'b010, 4'd2, 16'd500, 1'b0);
    tick();
    n_checks++;
    if (out_s !== 16'sd484) begin
      n_errors++;
      $display("FAIL ws_mac_pre_reset: got %0d want 484", out_s);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_s !== 16'sd0 || out_e !== 4'h0 || inst_e !== 3'b000 || valid_s !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_out: got out_s=%0d out_e=%0h inst_e=%b valid_s=%0b want 0", out_s, out_e, inst_e, valid_s);
    end
    n_checks++;
    if (dbg_ld !== 1'b1 || dbg_b !== 4'h0 || dbg_mode !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_state: got ld=%0b b_q=%0h mode=%0b want 1 0 0", dbg_ld, dbg_b, dbg_mode);
    end
    drive(3'b000, 4'd0, 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_s !== 16'sd0 || dbg_ld !== 1'b1 || dbg_acc !== 16'sd0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got out_s=%0d ld=%0b acc=%0d want 0 1 0", out_s, dbg_ld, dbg_acc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_ws_load();
    test_ws_mac();
    test_saturation();
    test_os_acc();
    test_priority();
    test_mode_gating();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
